pipelined_control_unit: RTL
===========================

Name: pipelined_control_unit

Overview:
- Five-stage successor to the single-cycle control unit.
- Decodes the 32-bit instruction in ID, then carries control and destination-register fields through ID/EX, EX/MEM and MEM/WB.
- Supports stall/flush bubbles, the full RV32I branch condition set (beq/bne/blt/bge/bltu/bgeu), and JAL/JALR/LUI.
- Sits between the IF/ID register and the datapath; the hazard unit consumes its rd/RegWrite/ResultSrc taps.

Parameters:
- DATA_WIDTH, 32, instruction width (opcode/funct fields are at fixed RV32 positions).
- REG_ADDR_W, 5, register-index width.
- ALU_CTRL_W, 4, ALUControl width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_d  in  DATA_WIDTH  instruction held in IF/ID.
- stall_d  in  1  ID held by the hazard unit; a bubble enters EX.
- flush_e  in  1  squash the instruction entering EX.
- zero_e  in  1  ALU result == 0.
- lt_e  in  1  signed rs1 < rs2.
- ltu_e  in  1  unsigned rs1 < rs2.
- ImmSrc_d  out  3  combinational immediate select: I=000, S=001, B=010, J=011, U=100.
- illegal_d  out  1  combinational; opcode not decoded.
- ALUControl_e  out  ALU_CTRL_W  EX ALU operation.
- ALUSrc_e  out  1  EX operand B is the immediate.
- PCSrc_e  out  1  take branch/jump.
- JumpReg_e  out  1  JALR: PC target is the ALU result.
- ResultSrc_e  out  2  EX-stage tap used for load-use detection.
- rd_e, rd_m, rd_w  out  REG_ADDR_W  destination index per stage.
- RegWrite_m, RegWrite_w  out  1  register write enable per stage.
- MemWrite_m  out  1  data-memory write.
- ResultSrc_w  out  2  WB select: ALU=00, mem=01, PC+4=10, imm=11.

Behaviour:
- Reset (rst_n low, asynchronous): every pipeline register clears to a bubble. All registered outputs are 0 (RegWrite, MemWrite, Branch, Jump, PCSrc_e=0; rd=0).
- Reset mid-operation discards all in-flight control. Release takes effect on the next rising edge.
- Decode, combinational in ID:
  - load 0000011: RegWrite, ALUSrc, I, ResultSrc=01, ALUOp=00.
  - store 0100011: MemWrite, ALUSrc, S, ALUOp=00.
  - R 0110011: RegWrite, ALUOp=10.
  - I-ALU 0010011: RegWrite, ALUSrc, I, ALUOp=10.
  - branch 1100011: Branch, B, ALUOp=01.
  - JAL 1101111: RegWrite, Jump, J, ResultSrc=10.
  - JALR 1100111: RegWrite, Jump, JumpReg, ALUSrc, I, ResultSrc=10.
  - LUI 0110111: RegWrite, U, ResultSrc=11.
  - Any other opcode: all controls 0 and illegal_d=1.
- ALU decode (add=0000, sub=0001, and=0010, or=0011, xor=0100, slt=0101, sltu=0110, sll=0111, srl=1000, sra=1001):
  - ALUOp=00 gives add; ALUOp=01 gives sub.
  - ALUOp=10 decodes funct3:
    - 000: sub only if op[5] & instr[30], else add.
    - 001: sll; 010: slt; 011: sltu; 100: xor.
    - 101: sra if instr[30], else srl.
    - 110: or; 111: and.
- Pipeline registers:
  - ID/EX latches the decoded bundle plus funct3 and rd=instr[11:7].
  - If flush_e OR stall_d, ID/EX loads a bubble (all enables 0, rd=0) instead.
  - EX/MEM and MEM/WB advance every cycle, never stalled.
- Latency: ID to EX outputs is 1 cycle; to _m outputs 2 cycles; to _w outputs 3 cycles.
- PCSrc_e = Jump_e OR (Branch_e AND cond). cond by funct3_e:
  - 000: zero_e; 001: !zero_e.
  - 100: lt_e; 101: !lt_e.
  - 110: ltu_e; 111: !ltu_e.
  - 010/011: 0.
- A bubble in EX forces PCSrc_e=0 regardless of zero/lt/ltu.
- Simultaneous flush_e and stall_d: bubble (same result as either alone).
- rd=x0 is carried as-is; suppressing writes to x0 is the register file's job.
- All outputs are registered except ImmSrc_d, illegal_d and PCSrc_e (combinational from EX registers and EX flags).

Decomposition:
- Package control_pkg holds:
  - opcode localparams;
  - imm_src_t, result_src_t and alu_ctrl_t enums with the encodings above;
  - ctrl_bundle_t struct: RegWrite, MemWrite, Branch, Jump, JumpReg, ALUSrc, ResultSrc, ALUControl, funct3, rd;
  - the BUBBLE constant.
- One sub-module, control_decoder: purely combinational, instr to ctrl_bundle_t, ImmSrc and illegal. The top contains only the three stage registers and branch resolution.

Test Plan:
- Reset: hold rst_n=0 mid-stream with an R-type in every stage -> all registered outputs 0 immediately, without waiting for a clock edge.
- add x3,x1,x2 (0x002081B3) -> next cycle ALUControl_e=0000, ALUSrc_e=0, rd_e=3; +2 cycles RegWrite_w=1, rd_w=3, ResultSrc_w=00. sub (0x402081B3) gives 0001.
- bge with lt_e=1 -> PCSrc_e=0; with lt_e=0 -> PCSrc_e=1. bltu with ltu_e=1 -> PCSrc_e=1. beq with zero_e=1 and flush_e=1 on the prior edge -> PCSrc_e=0.
- lw x5,0(x1) -> ResultSrc_e=01, rd_e=5. Same cycle stall_d=1 -> next cycle ID/EX bubble (RegWrite=0, rd_e=0), while MEM carries the lw (RegWrite_m=1, rd_m=5).
- jalr x1,0(x2) -> PCSrc_e=1, JumpReg_e=1, ALUSrc_e=1; ResultSrc_w=10 at WB.
- lui x4 -> ImmSrc_d=100, ResultSrc_w=11. Opcode 0x7F -> illegal_d=1, no write reaches WB.

Source files
------------

// File: rtl/control_pkg.sv
// Shared types and constants for the pipelined control unit.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package control_pkg;

   localparam int REG_IDX_W = 5;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10,
      RES_IMM = 2'b11
   } result_src_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLT  = 4'b0101,
      ALU_SLTU = 4'b0110,
      ALU_SLL  = 4'b0111,
      ALU_SRL  = 4'b1000,
      ALU_SRA  = 4'b1001
   } alu_ctrl_t;

   typedef struct packed {
      logic                 reg_write;
      logic                 mem_write;
      logic                 branch;
      logic                 jump;
      logic                 jump_reg;
      logic                 alu_src;
      result_src_t          result_src;
      alu_ctrl_t            alu_ctrl;
      logic [2:0]           funct3;
      logic [REG_IDX_W-1:0] rd;
   } ctrl_bundle_t;

   // A bubble has every enable low and rd=x0, so it is inert in every stage.
   localparam ctrl_bundle_t BUBBLE = '{
      reg_write:  1'b0,
      mem_write:  1'b0,
      branch:     1'b0,
      jump:       1'b0,
      jump_reg:   1'b0,
      alu_src:    1'b0,
      result_src: RES_ALU,
      alu_ctrl:   ALU_ADD,
      funct3:     3'b000,
      rd:         '0
   };

endpackage

// File: rtl/control_decoder.sv
// Combinational RV32 instruction decode into a control bundle, ImmSrc and illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the bundle is latched.
import control_pkg::*;

module control_decoder (
   input  logic [31:0]  instr,
   output ctrl_bundle_t ctrl,
   output imm_src_t     imm_src,
   output logic         illegal
);

   logic [6:0] op;
   logic [1:0] alu_op;
   logic       unused_bits;

   assign op          = instr[6:0];
   // Register-source fields and most of funct7 are consumed by the datapath, not here.
   assign unused_bits = ^{instr[31], instr[29:15]};

   // Main opcode decode followed by ALU operation selection.
   always_comb begin
      ctrl        = BUBBLE;
      ctrl.funct3 = instr[14:12];
      ctrl.rd     = instr[11:7];
      alu_op      = 2'b00;
      imm_src     = IMM_I;
      illegal     = 1'b0;
      case (op)
         OP_LOAD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RES_MEM;
         end
         OP_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            imm_src        = IMM_S;
         end
         OP_RTYPE: begin
            ctrl.reg_write = 1'b1;
            alu_op         = 2'b10;
         end
         OP_IALU: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            alu_op         = 2'b10;
         end
         OP_BRANCH: begin
            ctrl.branch = 1'b1;
            imm_src     = IMM_B;
            alu_op      = 2'b01;
         end
         OP_JAL: begin
            ctrl.reg_write  = 1'b1;
            ctrl.jump       = 1'b1;
            ctrl.result_src = RES_PC4;
            imm_src         = IMM_J;
         end
         OP_JALR: begin
            ctrl.reg_write  = 1'b1;
            ctrl.jump       = 1'b1;
            ctrl.jump_reg   = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RES_PC4;
         end
         OP_LUI: begin
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = RES_IMM;
            imm_src         = IMM_U;
         end
         default: begin
            ctrl    = BUBBLE;
            illegal = 1'b1;
         end
      endcase

      case (alu_op)
         2'b01:   ctrl.alu_ctrl = ALU_SUB;
         2'b10: begin
            case (instr[14:12])
               3'b000:  ctrl.alu_ctrl = (op[5] & instr[30]) ? ALU_SUB : ALU_ADD;
               3'b001:  ctrl.alu_ctrl = ALU_SLL;
               3'b010:  ctrl.alu_ctrl = ALU_SLT;
               3'b011:  ctrl.alu_ctrl = ALU_SLTU;
               3'b100:  ctrl.alu_ctrl = ALU_XOR;
               3'b101:  ctrl.alu_ctrl = instr[30] ? ALU_SRA : ALU_SRL;
               3'b110:  ctrl.alu_ctrl = ALU_OR;
               default: ctrl.alu_ctrl = ALU_AND;
            endcase
         end
         default: ctrl.alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/pipelined_control_unit.sv
// Five-stage control: decode in ID, carry control through ID/EX, EX/MEM, MEM/WB; resolve branches in EX.
// Latency: EX outputs 1 cycle after ID, _m outputs 2 cycles, _w outputs 3 cycles.
// Backpressure: stall_d or flush_e inserts a bubble into EX; later stages always advance.
import control_pkg::*;

module pipelined_control_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5,
   parameter int ALU_CTRL_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] instr_d,
   input  logic                  stall_d,
   input  logic                  flush_e,
   input  logic                  zero_e,
   input  logic                  lt_e,
   input  logic                  ltu_e,
   output logic [2:0]            ImmSrc_d,
   output logic                  illegal_d,
   output logic [ALU_CTRL_W-1:0] ALUControl_e,
   output logic                  ALUSrc_e,
   output logic                  PCSrc_e,
   output logic                  JumpReg_e,
   output logic [1:0]            ResultSrc_e,
   output logic [REG_ADDR_W-1:0] rd_e,
   output logic [REG_ADDR_W-1:0] rd_m,
   output logic [REG_ADDR_W-1:0] rd_w,
   output logic                  RegWrite_m,
   output logic                  RegWrite_w,
   output logic                  MemWrite_m,
   output logic [1:0]            ResultSrc_w
);

   ctrl_bundle_t dec_ctrl;
   imm_src_t     dec_imm;
   ctrl_bundle_t ex_q;
   logic         cond_e;

   control_decoder u_dec (
      .instr   (instr_d),
      .ctrl    (dec_ctrl),
      .imm_src (dec_imm),
      .illegal (illegal_d)
   );

   assign ImmSrc_d = dec_imm;

   // ID/EX: latch the decoded bundle, or a bubble when held or squashed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 ex_q <= BUBBLE;
      else if (flush_e || stall_d) ex_q <= BUBBLE;
      else                        ex_q <= dec_ctrl;
   end

   // EX/MEM: free-running, carries only what MEM and WB still need.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWrite_m <= 1'b0;
         MemWrite_m <= 1'b0;
         rd_m       <= '0;
      end else begin
         RegWrite_m <= ex_q.reg_write;
         MemWrite_m <= ex_q.mem_write;
         rd_m       <= ex_q.rd;
      end
   end

   logic [1:0] result_src_m;

   // MEM/WB: free-running; result_src rides along from EX/MEM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_src_m <= 2'b00;
         RegWrite_w   <= 1'b0;
         ResultSrc_w  <= 2'b00;
         rd_w         <= '0;
      end else begin
         result_src_m <= ex_q.result_src;
         RegWrite_w   <= RegWrite_m;
         ResultSrc_w  <= result_src_m;
         rd_w         <= rd_m;
      end
   end

   assign ALUControl_e = ex_q.alu_ctrl;
   assign ALUSrc_e     = ex_q.alu_src;
   assign JumpReg_e    = ex_q.jump_reg;
   assign ResultSrc_e  = ex_q.result_src;
   assign rd_e         = ex_q.rd;

   // Branch resolution: a bubble has branch=jump=0, so it can never redirect.
   always_comb begin
      cond_e = 1'b0;
      case (ex_q.funct3)
         3'b000:  cond_e = zero_e;
         3'b001:  cond_e = ~zero_e;
         3'b100:  cond_e = lt_e;
         3'b101:  cond_e = ~lt_e;
         3'b110:  cond_e = ltu_e;
         3'b111:  cond_e = ~ltu_e;
         default: cond_e = 1'b0;
      endcase
      PCSrc_e = ex_q.jump | (ex_q.branch & cond_e);
   end

endmodule
